// File: rtl/alu_pipe_shifter_pkg.sv
// rtl/alu_pipe_shifter_pkg.sv - shared shift op codes and elaboration helpers (SHIFTER_ROTATE_EN)
package alu_pipe_shifter_pkg;

  // Shift subset of the shared 4-bit ALU op encoding
  localparam logic [3:0] OP_SLL = 4'h1;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SRA = 4'hd;
  localparam logic [3:0] OP_ROL = 4'h3;
  localparam logic [3:0] OP_ROR = 4'h7;

  // Ceiling log2, used to size the shift-amount field
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // First level index owned by stage s; earlier stages take the ceiling share
  function automatic int stage_lo(input int shw, input int stages, input int s);
    int base;
    int rem;
    base = shw / stages;
    rem  = shw % stages;
    return s * base + ((s < rem) ? s : rem);
  endfunction

  // Stage that owns shift level lvl
  function automatic int level_stage(input int shw, input int stages, input int lvl);
    int st;
    st = 0;
    for (int s = 0; s < stages; s++) begin
      if (lvl >= stage_lo(shw, stages, s)) st = s;
    end
    return st;
  endfunction

  // Ops this build knows how to execute; anything else yields zero
  function automatic logic op_supported(input logic [3:0] op);
`ifdef SHIFTER_ROTATE_EN
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROL) || (op == OP_ROR);
`else
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`endif
  endfunction

endpackage

// File: rtl/alu_shift_level.sv
// rtl/alu_shift_level.sv - one conditional shift-by-2^LEVEL level (SHIFTER_ROTATE_EN)
module alu_shift_level
  import alu_pipe_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic [3:0]       op_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int SH = 1 << LEVEL;

  // Shift by SH when this level's amount bit is set; unknown ops pass through
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  data_o = {data_i[WIDTH-SH-1:0], {SH{1'b0}}};
        OP_SRL:  data_o = {{SH{1'b0}}, data_i[WIDTH-1:SH]};
        OP_SRA:  data_o = {{SH{sign_i}}, data_i[WIDTH-1:SH]};
`ifdef SHIFTER_ROTATE_EN
        OP_ROL:  data_o = {data_i[WIDTH-SH-1:0], data_i[WIDTH-1:WIDTH-SH]};
        OP_ROR:  data_o = {data_i[SH-1:0], data_i[WIDTH-1:SH]};
`endif
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe_shifter.sv
// rtl/alu_pipe_shifter.sv - pipelined logarithmic shifter with valid/ready and flush (SHIFTER_ROTATE_EN)
module alu_pipe_shifter
  import alu_pipe_shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = log2c(WIDTH);

  // Per-stage carried state; index STAGES-1 drives the outputs
  logic [WIDTH-1:0] val_q  [STAGES];
  logic [WIDTH-1:0] val_d  [STAGES];
  logic [SHW-1:0]   amt_q  [STAGES];
  logic [3:0]       op_q   [STAGES];
  logic             sign_q [STAGES];
  logic [TAG_W-1:0] tag_q  [STAGES];
  logic [STAGES-1:0] vld_q;

  logic [WIDTH-1:0] lvl_in  [SHW];
  logic [WIDTH-1:0] lvl_out [SHW];

  logic advance;

  assign out_valid = vld_q[STAGES-1];
  assign result    = val_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign in_ready  = !out_valid || out_ready;
  assign advance   = in_ready;

  // Shift levels, each fed by the previous level or by a stage register
  for (genvar i = 0; i < SHW; i++) begin : g_lvl
    localparam int S  = level_stage(SHW, STAGES, i);
    localparam int LO = stage_lo(SHW, STAGES, S);
    logic       en;
    logic [3:0] lop;
    logic       lsign;

    if (S == 0) begin : g_head
      assign en    = b[i];
      assign lop   = alu_op;
      assign lsign = a[WIDTH-1];
    end else begin : g_body
      assign en    = amt_q[S-1][i];
      assign lop   = op_q[S-1];
      assign lsign = sign_q[S-1];
    end

    if (i == LO) begin : g_first
      if (S == 0) begin : g_src_in
        assign lvl_in[i] = a;
      end else begin : g_src_reg
        assign lvl_in[i] = val_q[S-1];
      end
    end else begin : g_chain
      assign lvl_in[i] = lvl_out[i-1];
    end

    alu_shift_level #(
      .WIDTH(WIDTH),
      .LEVEL(i)
    ) u_level (
      .data_i(lvl_in[i]),
      .en_i  (en),
      .op_i  (lop),
      .sign_i(lsign),
      .data_o(lvl_out[i])
    );
  end

  // Stage register inputs; unsupported ops are zeroed once at accept time
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int HI = stage_lo(SHW, STAGES, s + 1) - 1;
    if (s == 0) begin : g_first
      assign val_d[s] = op_supported(alu_op) ? lvl_out[HI] : '0;
    end else begin : g_rest
      assign val_d[s] = lvl_out[HI];
    end
  end

  // Pipeline registers: flush clears valids, otherwise all stages move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        val_q[s]  <= '0;
        amt_q[s]  <= '0;
        op_q[s]   <= '0;
        sign_q[s] <= 1'b0;
        tag_q[s]  <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q[0]  <= in_valid;
      val_q[0]  <= val_d[0];
      amt_q[0]  <= b[SHW-1:0];
      op_q[0]   <= alu_op;
      sign_q[0] <= a[WIDTH-1];
      tag_q[0]  <= in_tag;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s]  <= vld_q[s-1];
        val_q[s]  <= val_d[s];
        amt_q[s]  <= amt_q[s-1];
        op_q[s]   <= op_q[s-1];
        sign_q[s] <= sign_q[s-1];
        tag_q[s]  <= tag_q[s-1];
      end
    end
  end

  // Upper amount bits are ignored by definition; last-stage control is never consumed
  logic unused_sig;
  assign unused_sig = ^{b[WIDTH-1:SHW], amt_q[STAGES-1], op_q[STAGES-1], sign_q[STAGES-1]};

endmodule

// File: tb/tb_alu_pipe_shifter.sv
// tb/tb_alu_pipe_shifter.sv - self-checking bench for alu_pipe_shifter (SHIFTER_ROTATE_EN)
module tb_alu_pipe_shifter;
  import alu_pipe_shifter_pkg::*;

  localparam int W = 32;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [W-1:0] result;
  logic [4:0]  out_tag;

  int checks;
  int failures;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   tag;
  } exp_t;
  exp_t q[$];

  logic [3:0] op_tab[6];

  alu_pipe_shifter #(.WIDTH(W), .STAGES(2), .TAG_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_tag  (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the amount modulo WIDTH
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] amt);
    int sh;
    logic signed [W-1:0] sx;
    sh = int'(amt % W);
    sx = x;
    case (op)
      OP_SLL: return x << sh;
      OP_SRL: return x >> sh;
      OP_SRA: return sx >>> sh;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: return (sh == 0) ? x : ((x << sh) | (x >> (W - sh)));
      OP_ROR: return (sh == 0) ? x : ((x >> sh) | (x << (W - sh)));
`endif
      default: return '0;
    endcase
  endfunction

  task automatic rand_op();
    int k;
    k = $urandom_range(0, 6);
    alu_op = (k == 6) ? 4'($urandom_range(0, 15)) : op_tab[k];
    a      = $urandom;
    b      = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, W - 1));
    in_tag = 5'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = OP_SLL; a = '0; b = '0; in_tag = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || out_tag !== '0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b result=%h out_tag=%0d, required 0/0/0",
               out_valid, result, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]   d_op[6];
    logic [W-1:0] d_a[6], d_b[6], d_exp[6];
    d_op[0] = OP_SLL; d_a[0] = 32'h0000_00F1; d_b[0] = 32'd4;  d_exp[0] = 32'h0000_0F10;
    d_op[1] = OP_SRA; d_a[1] = 32'h8000_0000; d_b[1] = 32'd31; d_exp[1] = 32'hFFFF_FFFF;
    d_op[2] = OP_SRL; d_a[2] = 32'h8000_0000; d_b[2] = 32'd31; d_exp[2] = 32'h0000_0001;
    d_op[3] = OP_SRL; d_a[3] = 32'h8000_0000; d_b[3] = 32'd32; d_exp[3] = 32'h8000_0000;
    d_op[4] = OP_ROL; d_a[4] = 32'h8000_0001; d_b[4] = 32'd1;
    d_op[5] = OP_ROR; d_a[5] = 32'h0000_0001; d_b[5] = 32'd1;
`ifdef SHIFTER_ROTATE_EN
    d_exp[4] = 32'h0000_0003; d_exp[5] = 32'h8000_0000;
`else
    d_exp[4] = 32'h0000_0000; d_exp[5] = 32'h0000_0000;
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      alu_op = d_op[i]; a = d_a[i]; b = d_b[i]; in_tag = 5'(i + 3);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL latency_early[%0d]: out_valid=%b after 1 cycle, required 0", i, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || result !== d_exp[i] || out_tag !== 5'(i + 3)) begin
        failures++;
        $display("FAIL directed[%0d]: out_valid=%b result=%h tag=%0d, required 1 %h %0d",
                 i, out_valid, result, out_tag, d_exp[i], i + 3);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic         held_v;
    logic [W-1:0] held_res;
    logic [4:0]   held_tag;
    exp_t         e;
    q.delete();
    held_v = 1'b0; held_res = '0; held_tag = '0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      flush     = 1'b0;
      in_valid  = (c < 10);
      out_ready = !(c >= 4 && c < 7);
      rand_op();
      #1;
      if (c >= 4 && c < 7) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_stall_ready[%0d]: in_ready=%b, required 0", c, in_ready);
        end
      end
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || result !== held_res || out_tag !== held_tag) begin
          failures++;
          $display("FAIL b2b_stable[%0d]: %b %h %0d, required 1 %h %0d",
                   c, out_valid, result, out_tag, held_res, held_tag);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_spurious[%0d]: result=%h with nothing outstanding", c, result);
        end else begin
          e = q.pop_front();
          if (result !== e.res || out_tag !== e.tag) begin
            failures++;
            $display("FAIL b2b_data[%0d]: result=%h tag=%0d, required %h %0d",
                     c, result, out_tag, e.res, e.tag);
          end
        end
      end
      if (in_valid && in_ready) q.push_back('{model(alu_op, a, b), in_tag});
      held_v = out_valid && !out_ready; held_res = result; held_tag = out_tag;
      @(posedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL b2b_lost: %0d ops never emerged, required 0", q.size());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; rand_op();
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b1; rand_op();
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_setup: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_drop[%0d]: out_valid=%b result=%h, required 0", c, out_valid, result);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic         held_v;
    logic [W-1:0] held_res;
    logic [4:0]   held_tag;
    exp_t         e;
    q.delete();
    held_v = 1'b0; held_res = '0; held_tag = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rand_op();
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL rnd_ready[%0d]: in_ready=%b out_valid=%b out_ready=%b",
                 c, in_ready, out_valid, out_ready);
      end
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || result !== held_res || out_tag !== held_tag) begin
          failures++;
          $display("FAIL rnd_stable[%0d]: %b %h %0d, required 1 %h %0d",
                   c, out_valid, result, out_tag, held_res, held_tag);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious[%0d]: result=%h with nothing outstanding", c, result);
        end else begin
          e = q.pop_front();
          if (result !== e.res || out_tag !== e.tag) begin
            failures++;
            $display("FAIL rnd_data[%0d]: result=%h tag=%0d, required %h %0d",
                     c, result, out_tag, e.res, e.tag);
          end
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{model(alu_op, a, b), in_tag});
      held_v = out_valid && !out_ready && !flush; held_res = result; held_tag = out_tag;
      @(posedge clk);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_drain_spurious: result=%h with nothing outstanding", result);
        end else begin
          e = q.pop_front();
          if (result !== e.res || out_tag !== e.tag) begin
            failures++;
            $display("FAIL rnd_drain_data: result=%h tag=%0d, required %h %0d",
                     result, out_tag, e.res, e.tag);
          end
        end
      end
      @(posedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rnd_lost: %0d ops never emerged, required 0", q.size());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      alu_op = OP_SLL; a = 32'hFFFF_0000; b = 32'd3; in_tag = 5'd9;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup: out_valid=%b before reset, required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || out_tag !== '0) begin
      failures++;
      $display("FAIL arst_immediate: out_valid=%b result=%h tag=%0d, required 0 0 0",
               out_valid, result, out_tag);
    end
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; alu_op = OP_SLL; a = 32'h1; b = 32'd1; in_tag = 5'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_latency_early: out_valid=%b, required 0", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h2 || out_tag !== 5'd7) begin
      failures++;
      $display("FAIL arst_first_op: %b %h %0d, required 1 00000002 7", out_valid, result, out_tag);
    end
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    op_tab = '{OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, 4'hf};
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
